sample_trigger_gen: RTL and testbench

//  Consumes the 32-bit sample period (in aclk cycles) from the timebase scale decoder.

---
 rtl/ad7276_pkg.sv | 15 +
 rtl/sample_period_counter.sv | 54 +++++
 rtl/sample_trigger_gen.sv | 107 ++++++++++
 tb/tb_sample_trigger_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad7276_pkg.sv
// Shared definitions for the AD7276 sample trigger path: default widths,
// the minimum legal sample period and the trigger FSM state type.
package ad7276_pkg;

  localparam int DEFAULT_CNT_W      = 32;
  localparam int DEFAULT_OVR_W      = 16;
  localparam int DEFAULT_MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } trig_state_t;

endpackage

// File: rtl/sample_period_counter.sv
// Loadable down-counter that paces the sample trigger. It raises
// terminal_count for one cycle at the end of every period and keeps the
// period currently in force in period_q.
module sample_period_counter
  import ad7276_pkg::*;
#(
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             terminal_count
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

  logic [CNT_W-1:0] eff_period;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] period_q;
  logic             run_q;

  // Requested periods shorter than the minimum are clamped up to it.
  assign eff_period = (period < MIN_P) ? MIN_P : period;

  // Load on the first enabled cycle, count down, and reload from period_q at zero.
  // period_q picks up the requested period one cycle before each reload, so a
  // change made mid-interval only affects the interval after the next tick.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count    <= '0;
      period_q <= MIN_P;
      run_q    <= 1'b0;
    end else if (!enable) begin
      count <= '0;
      run_q <= 1'b0;
    end else if (!run_q) begin
      run_q    <= 1'b1;
      count    <= eff_period - 1'b1;
      period_q <= eff_period;
    end else if (count == '0) begin
      count <= period_q - 1'b1;
    end else begin
      count <= count - 1'b1;
      if (count == CNT_W'(1)) begin
        period_q <= eff_period;
      end
    end
  end

  assign terminal_count = run_q && (count == '0);

endmodule

// File: rtl/sample_trigger_gen.sv
// Periodic sample trigger for the AD7276 capture core. Emits sample_tick
// every period, forwards it as adc_start when the core is ready, holds at
// most one request while the core is busy, and counts dropped ticks.
module sample_trigger_gen
  import ad7276_pkg::*;
#(
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int OVR_W      = DEFAULT_OVR_W,
  parameter int MIN_PERIOD = DEFAULT_MIN_PERIOD
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic [CNT_W-1:0] time_sampling,
  input  logic             adc_ready,
  input  logic             clr_overrun,
  output logic             sample_tick,
  output logic             adc_start,
  output logic             pending,
  output logic             overrun,
  output logic [OVR_W-1:0] overrun_count
);

  trig_state_t state;
  logic        tc;
  logic        defer_q;

  sample_period_counter #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_counter (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .enable         (enable),
    .period         (time_sampling),
    .terminal_count (tc)
  );

  // Trigger FSM. defer_q carries a tick that landed in the same cycle as a
  // held start was issued; it is serviced in RUN one cycle later, and since
  // adc_start was just high it always parks in PEND to avoid back-to-back starts.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      sample_tick <= 1'b0;
      adc_start   <= 1'b0;
      pending     <= 1'b0;
      defer_q     <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      sample_tick <= 1'b0;
      adc_start   <= 1'b0;
      pending     <= 1'b0;
      defer_q     <= 1'b0;
    end else begin
      sample_tick <= tc;
      adc_start   <= 1'b0;
      defer_q     <= 1'b0;
      unique case (state)
        IDLE: begin
          state   <= RUN;
          pending <= 1'b0;
        end
        RUN: begin
          if (tc || defer_q) begin
            if (adc_ready && !adc_start) begin
              adc_start <= 1'b1;
            end else begin
              state <= PEND;
            end
          end
        end
        PEND: begin
          if (adc_ready) begin
            adc_start <= 1'b1;
            pending   <= 1'b0;
            defer_q   <= tc;
            state     <= RUN;
          end else begin
            pending <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun flag and saturating drop counter; a clear beats a same-cycle increment.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else if (clr_overrun) begin
      overrun       <= 1'b0;
      overrun_count <= '0;
    end else if (enable && (state == PEND) && tc && !adc_ready) begin
      overrun <= 1'b1;
      if (overrun_count != '1) begin
        overrun_count <= overrun_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_trigger_gen.sv
// Bench for sample_trigger_gen: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
module tb_sample_trigger_gen;

  localparam int OVR_W_TB = 4;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic                enable = 1'b0;
  logic [31:0]         time_sampling = 32'd0;
  logic                adc_ready = 1'b1;
  logic                clr_overrun = 1'b0;
  logic                sample_tick;
  logic                adc_start;
  logic                pending;
  logic                overrun;
  logic [OVR_W_TB-1:0] overrun_count;

  int vectors = 0;
  int miscompares = 0;
  int rel = 0;

  sample_trigger_gen #(
    .CNT_W (32),
    .OVR_W (OVR_W_TB)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .time_sampling (time_sampling),
    .adc_ready     (adc_ready),
    .clr_overrun   (clr_overrun),
    .sample_tick   (sample_tick),
    .adc_start     (adc_start),
    .pending       (pending),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  // 10 ns clock
  always #5 aclk = ~aclk;

  // Behavioural model: time left until the next tick, one held request at most.
  bit        m_run = 1'b0;
  bit        m_held = 1'b0;
  bit        m_defer = 1'b0;
  bit        m_prev_start = 1'b0;
  int        m_left = 0;
  int        m_next_p = 2;
  bit        e_tick = 1'b0;
  bit        e_start = 1'b0;
  bit        e_pend = 1'b0;
  bit        e_ovr = 1'b0;
  logic [3:0] e_cnt = 4'd0;

  task automatic modelStep();
    int p_req;
    bit tick_now;
    bit defer_now;
    bit inc;
    p_req = (time_sampling < 32'd2) ? 2 : int'(time_sampling);
    inc = 1'b0;
    if (!aresetn) begin
      m_run = 0; m_held = 0; m_defer = 0;
      e_tick = 0; e_start = 0; e_pend = 0; e_ovr = 0; e_cnt = 4'd0;
    end else begin
      if (!enable) begin
        m_run = 0; m_held = 0; m_defer = 0;
        e_tick = 0; e_start = 0; e_pend = 0;
      end else if (!m_run) begin
        m_run = 1; m_left = p_req; m_next_p = p_req;
        e_tick = 0; e_start = 0; e_pend = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 1) m_next_p = p_req;
        tick_now = (m_left == 0);
        if (tick_now) m_left = m_next_p;
        defer_now = m_defer;
        m_defer = 0;
        e_tick = tick_now;
        e_start = 0;
        if (m_held) begin
          if (adc_ready) begin
            e_start = 1; m_held = 0; e_pend = 0; m_defer = tick_now;
          end else begin
            e_pend = 1; inc = tick_now;
          end
        end else if (tick_now || defer_now) begin
          if (adc_ready && !m_prev_start) e_start = 1;
          else m_held = 1;
        end
      end
      if (clr_overrun) begin
        e_ovr = 0; e_cnt = 4'd0;
      end else if (inc) begin
        e_ovr = 1;
        if (e_cnt != 4'd15) e_cnt = e_cnt + 4'd1;
      end
    end
    m_prev_start = e_start;
  endtask

  task automatic applyStimulus(input bit rstn, input bit en, input logic [31:0] ts,
                               input bit rdy, input bit clr);
    aresetn = rstn;
    enable = en;
    time_sampling = ts;
    adc_ready = rdy;
    clr_overrun = clr;
  endtask

  task automatic checkOutput(input string name, input bit tick, input bit start,
                             input bit pend, input bit ovr, input logic [3:0] cnt);
    vectors++;
    if (sample_tick !== tick || adc_start !== start || pending !== pend ||
        overrun !== ovr || overrun_count !== cnt) begin
      miscompares++;
      $display("[TB] FAIL %s rel=%0d: got tick=%b start=%b pend=%b ovr=%b cnt=%0d, expected tick=%b start=%b pend=%b ovr=%b cnt=%0d",
               name, rel, sample_tick, adc_start, pending, overrun, overrun_count,
               tick, start, pend, ovr, cnt);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input bit exp);
    vectors++;
    if (actual !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s rel=%0d: got %b, expected %b", name, rel, actual, exp);
    end
  endtask

  task automatic checkCount(input string name, input logic [3:0] actual, input logic [3:0] exp);
    vectors++;
    if (actual !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s rel=%0d: got %0d, expected %0d", name, rel, actual, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge aclk);
    #1;
    rel++;
  endtask

  // Idle for two cycles, then raise enable; returns just after edge t0 with rel=0.
  task automatic startRun(input int p, input bit rdy);
    applyStimulus(1, 0, p, rdy, 0);
    stepCycle();
    stepCycle();
    applyStimulus(1, 1, p, rdy, 0);
    stepCycle();
    rel = 0;
  endtask

  // Model comparison on every cycle
  always @(posedge aclk) begin
    modelStep();
    #1;
    checkOutput("model", e_tick, e_start, e_pend, e_ovr, e_cnt);
  end

  typedef struct {
    bit         rstn;
    bit         en;
    logic [31:0] ts;
    bit         rdy;
    bit         clr;
    bit         tick;
    bit         start;
    bit         pend;
    bit         ovr;
    logic [3:0] cnt;
  } vec_t;

  function automatic vec_t mk(bit rstn, bit en, int ts, bit rdy, bit clr,
                              bit tick, bit start, bit pend, bit ovr, int cnt);
    vec_t v;
    v.rstn = rstn; v.en = en; v.ts = 32'(ts); v.rdy = rdy; v.clr = clr;
    v.tick = tick; v.start = start; v.pend = pend; v.ovr = ovr; v.cnt = 4'(cnt);
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    bit en_r;
    bit rdy_r;
    bit clr_r;
    bit rst_r;
    logic [31:0] ts_r;

    // rstn en ts rdy clr | tick start pend ovr cnt
    vecs.push_back(mk(0,0,0,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,0,1,0, 1,1,0,0,0));
    vecs.push_back(mk(1,1,0,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,1,0, 1,1,0,0,0));
    vecs.push_back(mk(1,1,1,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,1,0, 1,1,0,0,0));
    vecs.push_back(mk(1,1,1,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,1,0, 1,1,0,0,0));
    vecs.push_back(mk(1,0,1,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,2,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,2,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,2,0,0, 1,0,0,0,0));
    vecs.push_back(mk(1,1,2,0,0, 0,0,1,0,0));
    vecs.push_back(mk(1,1,2,0,0, 1,0,1,1,1));
    vecs.push_back(mk(1,1,2,1,0, 0,1,0,1,1));
    vecs.push_back(mk(1,1,2,0,0, 1,0,0,1,1));
    vecs.push_back(mk(1,1,2,0,0, 0,0,1,1,1));
    vecs.push_back(mk(1,0,2,1,0, 0,0,0,1,1));
    vecs.push_back(mk(1,0,2,1,1, 0,0,0,0,0));
    vecs.push_back(mk(1,1,2,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,2,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,2,1,0, 1,1,0,0,0));
    vecs.push_back(mk(1,1,2,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,2,0,0, 1,0,0,0,0));
    vecs.push_back(mk(1,1,2,0,0, 0,0,1,0,0));
    vecs.push_back(mk(1,1,2,1,0, 1,1,0,0,0));
    vecs.push_back(mk(1,1,2,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,2,1,0, 1,1,0,0,0));
    vecs.push_back(mk(1,1,2,1,0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,2,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,2,0,0, 0,0,0,0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstn, vecs[i].en, vecs[i].ts, vecs[i].rdy, vecs[i].clr);
      stepCycle();
      checkOutput($sformatf("vec%0d", i), vecs[i].tick, vecs[i].start, vecs[i].pend,
                  vecs[i].ovr, vecs[i].cnt);
    end

    $display("[TB] steady period 100");
    startRun(100, 1);
    for (int i = 1; i <= 300; i++) begin
      stepCycle();
      checkBit("p100 tick", sample_tick, (i % 100) == 0);
      checkBit("p100 start", adc_start, (i % 100) == 0);
    end
    checkCount("p100 ovr count", overrun_count, 4'd0);

    $display("[TB] period change 100 -> 200");
    startRun(100, 1);
    for (int i = 1; i <= 600; i++) begin
      stepCycle();
      checkBit("chg tick", sample_tick, i == 100 || i == 200 || i == 400 || i == 600);
      if (i == 150) applyStimulus(1, 1, 200, 1, 0);
    end

    $display("[TB] late ready");
    startRun(100, 0);
    for (int i = 1; i <= 140; i++) begin
      stepCycle();
      checkBit("late tick", sample_tick, i == 100);
      checkBit("late pending", pending, i >= 101 && i <= 130);
      checkBit("late start", adc_start, i == 131);
      if (i == 130) applyStimulus(1, 1, 100, 1, 0);
    end
    checkBit("late overrun", overrun, 1'b0);

    $display("[TB] overrun and clear");
    startRun(100, 0);
    for (int i = 1; i <= 261; i++) begin
      stepCycle();
      checkBit("ovr tick", sample_tick, i == 100 || i == 200);
      checkBit("ovr start", adc_start, i == 251);
      checkBit("ovr flag", overrun, i >= 200 && i <= 260);
      checkCount("ovr count", overrun_count, (i >= 200 && i <= 260) ? 4'd1 : 4'd0);
      if (i == 250) applyStimulus(1, 1, 100, 1, 0);
      if (i == 260) applyStimulus(1, 1, 100, 1, 1);
      if (i == 261) applyStimulus(1, 1, 100, 1, 0);
    end

    $display("[TB] saturation and clear priority");
    startRun(2, 0);
    for (int i = 1; i <= 44; i++) begin
      stepCycle();
      if (i == 30) checkCount("sat count30", overrun_count, 4'd14);
      if (i == 32) checkCount("sat count32", overrun_count, 4'd15);
      if (i == 40) checkCount("sat count40", overrun_count, 4'd15);
      if (i == 42) begin
        checkCount("clr wins count", overrun_count, 4'd0);
        checkBit("clr wins flag", overrun, 1'b0);
      end
      if (i == 44) checkCount("after clr count", overrun_count, 4'd1);
      applyStimulus(1, 1, 2, 0, i == 41);
    end

    $display("[TB] disable while pending");
    startRun(100, 0);
    for (int i = 1; i <= 110; i++) stepCycle();
    checkBit("pend before drop", pending, 1'b1);
    applyStimulus(1, 0, 100, 0, 0);
    stepCycle();
    checkBit("drop pending", pending, 1'b0);
    applyStimulus(1, 0, 100, 1, 0);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkBit("drop no start", adc_start, 1'b0);
    end
    applyStimulus(1, 1, 100, 1, 0);
    stepCycle();
    rel = 0;
    for (int i = 1; i <= 100; i++) begin
      stepCycle();
      checkBit("reen tick", sample_tick, i == 100);
      checkBit("reen start", adc_start, i == 100);
    end

    $display("[TB] reset while pending");
    startRun(100, 0);
    for (int i = 1; i <= 105; i++) stepCycle();
    applyStimulus(0, 1, 100, 1, 0);
    stepCycle();
    checkBit("rst pending", pending, 1'b0);
    checkBit("rst start", adc_start, 1'b0);
    applyStimulus(1, 1, 100, 1, 0);
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      checkBit("post rst start", adc_start, 1'b0);
      checkBit("post rst pending", pending, 1'b0);
    end

    $display("[TB] randomized run");
    en_r = 1'b1;
    ts_r = 32'd3;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(199) == 0) en_r = ~en_r;
      if ($urandom_range(49) == 0) ts_r = $urandom_range(12);
      rdy_r = ($urandom_range(1) == 1);
      clr_r = ($urandom_range(39) == 0);
      rst_r = ($urandom_range(499) != 0);
      applyStimulus(rst_r, en_r, ts_r, rdy_r, clr_r);
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
